alu_result_checker: RTL and testbench

ALU_RESULT_CHECKER -- requirements
Module: alu_result_checker

---
 rtl/alu_result_checker.sv | 179 +++++++++++++++++
 tb/tb_alu_result_checker.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_checker.sv
// Golden-model checker for a small ALU: computes the expected result, waits for the
// DUT result and scores it. Optional WAIT timeout via `define CHK_TIMEOUT_EN.
module alu_result_checker #(
    parameter int BITS        = 16,
    parameter int TIMEOUT     = 15,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [BITS-1:0] sw,
    input  logic            res_valid,
    input  logic [BITS-1:0] res,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [BITS-1:0] expected,
    output logic [15:0]     test_cnt,
    output logic [15:0]     error_cnt,
    output logic            timeout_err,
    output logic            halted
);

    localparam int H = BITS / 2;

    localparam logic [2:0] OP_LEAD = 3'd0;
    localparam logic [2:0] OP_ONES = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_MULT = 3'd4;

    typedef enum logic [1:0] {IDLE, WAIT, COMPARE, HALT} state_t;

    if ((BITS % 2) != 0 || BITS < 4 || TIMEOUT < 1) begin : g_bad_param
        $error("alu_result_checker: illegal BITS/TIMEOUT");
    end

    state_t          state_q, state_d;
    logic [BITS-1:0] exp_q, exp_d;
    logic            pass_q, pass_d;
    logic [15:0]     tcnt_q, tcnt_d;
    logic [15:0]     ecnt_q, ecnt_d;

    logic signed [BITS-1:0] a, b;
    logic [BITS-1:0]        lead, ones, golden;
    logic                   legal;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        a      = {{H{sw[BITS-1]}}, sw[BITS-1:H]};
        b      = {{H{sw[H-1]}}, sw[H-1:0]};
        lead   = '0;
        ones   = '0;
        golden = '0;
        for (int i = 0; i < BITS; i++) begin
            if (sw[i]) begin
                lead = BITS'(i + 1);
                ones = ones + BITS'(1);
            end
        end
        unique case (op)
            OP_LEAD: golden = lead;
            OP_ONES: golden = ones;
            OP_ADD:  golden = a + b;
            OP_SUB:  golden = a - b;
            OP_MULT: golden = a * b;
            default: golden = '0;
        endcase
    end

    assign legal = (op <= OP_MULT);

`ifdef CHK_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic          tmo_q, tmo_d;
`endif

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        pass_d  = pass_q;
        tcnt_d  = tcnt_q;
        ecnt_d  = ecnt_q;
`ifdef CHK_TIMEOUT_EN
        wcnt_d  = wcnt_q;
        tmo_d   = tmo_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    exp_d = golden;
`ifdef CHK_TIMEOUT_EN
                    tmo_d  = 1'b0;
                    wcnt_d = '0;
`endif
                    if (legal) begin
                        state_d = WAIT;
                    end else begin
                        // Illegal opcodes are scored immediately as failures.
                        pass_d  = 1'b0;
                        tcnt_d  = sat_inc(tcnt_q);
                        ecnt_d  = sat_inc(ecnt_q);
                        state_d = COMPARE;
                    end
                end
            end
            WAIT: begin
                if (res_valid) begin
                    pass_d  = (res == exp_q);
                    tcnt_d  = sat_inc(tcnt_q);
                    if (res != exp_q) ecnt_d = sat_inc(ecnt_q);
                    state_d = COMPARE;
`ifdef CHK_TIMEOUT_EN
                end else if (wcnt_q == CW'(TIMEOUT - 1)) begin
                    pass_d  = 1'b0;
                    tmo_d   = 1'b1;
                    tcnt_d  = sat_inc(tcnt_q);
                    ecnt_d  = sat_inc(ecnt_q);
                    state_d = COMPARE;
                end else begin
                    wcnt_d = wcnt_q + CW'(1);
`endif
                end
            end
            COMPARE: begin
                state_d = (STOP_ON_ERR && !pass_q) ? HALT : IDLE;
            end
            HALT: begin
                state_d = HALT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            exp_q   <= '0;
            pass_q  <= 1'b0;
            tcnt_q  <= '0;
            ecnt_q  <= '0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            pass_q  <= pass_d;
            tcnt_q  <= tcnt_d;
            ecnt_q  <= ecnt_d;
        end
    end

`ifdef CHK_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt_q <= '0;
            tmo_q  <= 1'b0;
        end else begin
            wcnt_q <= wcnt_d;
            tmo_q  <= tmo_d;
        end
    end
    assign timeout_err = tmo_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == COMPARE);
    assign halted    = (state_q == HALT);
    assign pass      = pass_q;
    assign expected  = exp_q;
    assign test_cnt  = tcnt_q;
    assign error_cnt = ecnt_q;

endmodule

// File: tb/tb_alu_result_checker.sv
// Bench for alu_result_checker: vector table with scoreboard plus
// timeout, halt and reset sequences.
module tb_alu_result_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, res_valid;
    logic [2:0]  op;
    logic [15:0] sw, res;
    logic        busy, done, pass, timeout_err, halted;
    logic [15:0] expected, test_cnt, error_cnt;

    logic        h_reset, h_start;
    logic        h_busy, h_done, h_pass, h_timeout_err, h_halted;
    logic [15:0] h_expected, h_test_cnt, h_error_cnt;

    alu_result_checker #(.BITS(16), .TIMEOUT(15), .STOP_ON_ERR(1'b0)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .sw(sw),
        .res_valid(res_valid), .res(res), .busy(busy), .done(done),
        .pass(pass), .expected(expected), .test_cnt(test_cnt),
        .error_cnt(error_cnt), .timeout_err(timeout_err), .halted(halted)
    );

    alu_result_checker #(.BITS(16), .TIMEOUT(15), .STOP_ON_ERR(1'b1)) dut_h (
        .clk(clk), .reset(h_reset), .start(h_start), .op(op), .sw(sw),
        .res_valid(res_valid), .res(res), .busy(h_busy), .done(h_done),
        .pass(h_pass), .expected(h_expected), .test_cnt(h_test_cnt),
        .error_cnt(h_error_cnt), .timeout_err(h_timeout_err),
        .halted(h_halted)
    );

    int checks   = 0;
    int failures = 0;
    int m_tests  = 0;
    int m_errs   = 0;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] sw;
        logic [15:0] res;
        logic [15:0] exp;
        logic        pass;
    } vec_t;

    typedef struct {
        logic [15:0] exp;
        logic        pass;
        logic        legal;
    } sb_t;

    vec_t vecs[12];
    sb_t  sbq[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string p, input logic [4:0] fl,
                            input logic [15:0] e, input logic [15:0] t,
                            input logic [15:0] er);
        chk({p, "_flags"}, {27'd0, fl}, 32'd0);
        chk({p, "_expected"}, {16'd0, e}, 32'd0);
        chk({p, "_test_cnt"}, {16'd0, t}, 32'd0);
        chk({p, "_error_cnt"}, {16'd0, er}, 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        sb_t  e;
        int   n;
        logic legal;
        legal   = (v.op <= 3'd4);
        e.exp   = v.exp;
        e.pass  = v.pass;
        e.legal = legal;
        sbq.push_back(e);
        start = 1'b1;
        op    = v.op;
        sw    = v.sw;
        tick();
        start = 1'b0;
        if (legal) begin
            chk($sformatf("busy_wait[%0d]", idx), {31'd0, busy}, 32'd1);
            res       = v.res;
            res_valid = 1'b1;
            tick();
            res_valid = 1'b0;
        end
        n = 0;
        while (!done && n < 5) begin
            tick();
            n++;
        end
        chk($sformatf("latency[%0d]", idx), n, 0);
        if (done) begin
            e = sbq.pop_front();
            if (e.legal)
                chk($sformatf("expected[%0d]", idx), {16'd0, expected},
                    {16'd0, e.exp});
            chk($sformatf("pass[%0d]", idx), {31'd0, pass}, {31'd0, e.pass});
            m_tests++;
            if (!e.pass) m_errs++;
            chk($sformatf("test_cnt[%0d]", idx), {16'd0, test_cnt}, m_tests);
            chk($sformatf("error_cnt[%0d]", idx), {16'd0, error_cnt}, m_errs);
        end
        tick();
        chk($sformatf("idle[%0d]", idx), {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        logic seen;
        reset     = 1'b1;
        h_reset   = 1'b1;
        start     = 1'b0;
        h_start   = 1'b0;
        res_valid = 1'b0;
        op        = 3'd0;
        sw        = '0;
        res       = '0;
        tick();
        tick();
        reset   = 1'b0;
        h_reset = 1'b0;
        chk_zero("rst", {busy, done, pass, timeout_err, halted},
                 expected, test_cnt, error_cnt);
        chk_zero("h_rst", {h_busy, h_done, h_pass, h_timeout_err, h_halted},
                 h_expected, h_test_cnt, h_error_cnt);

        vecs[0]  = '{3'd2, 16'h7F01, 16'h0080, 16'h0080, 1'b1};
        vecs[1]  = '{3'd3, 16'h8001, 16'hFF7F, 16'hFF7F, 1'b1};
        vecs[2]  = '{3'd4, 16'h8080, 16'h4001, 16'h4000, 1'b0};
        vecs[3]  = '{3'd0, 16'h0000, 16'h0000, 16'h0000, 1'b1};
        vecs[4]  = '{3'd0, 16'h8000, 16'h0010, 16'h0010, 1'b1};
        vecs[5]  = '{3'd1, 16'hFFFF, 16'h0010, 16'h0010, 1'b1};
        vecs[6]  = '{3'd1, 16'h00F3, 16'h0006, 16'h0006, 1'b1};
        vecs[7]  = '{3'd0, 16'h0123, 16'h0009, 16'h0009, 1'b1};
        vecs[8]  = '{3'd2, 16'hFFFF, 16'hFFFE, 16'hFFFE, 1'b1};
        vecs[9]  = '{3'd4, 16'h7F7F, 16'h3F01, 16'h3F01, 1'b1};
        vecs[10] = '{3'd3, 16'h0580, 16'h0084, 16'h0085, 1'b0};
        vecs[11] = '{3'd5, 16'h1234, 16'h0000, 16'h0000, 1'b0};

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

`ifdef CHK_TIMEOUT_EN
        start = 1'b1;
        op    = 3'd2;
        sw    = 16'h7F01;
        tick();
        start = 1'b0;
        n = 1;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        chk("tmo_cycle", n, 16);
        chk("tmo_err", {31'd0, timeout_err}, 32'd1);
        chk("tmo_pass", {31'd0, pass}, 32'd0);
        m_tests++;
        m_errs++;
        chk("tmo_error_cnt", {16'd0, error_cnt}, m_errs);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("tmo_clr", {31'd0, timeout_err}, 32'd0);
        n = 1;
        while (n < 15) begin
            tick();
            n++;
        end
        chk("tmo_edge_nodone", {31'd0, done}, 32'd0);
        res       = 16'h0080;
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        chk("tmo_edge_done", {31'd0, done}, 32'd1);
        chk("tmo_edge_err", {31'd0, timeout_err}, 32'd0);
        chk("tmo_edge_pass", {31'd0, pass}, 32'd1);
        m_tests++;
        chk("tmo_edge_cnt", {16'd0, test_cnt}, m_tests);
        tick();
`else
        start = 1'b1;
        op    = 3'd2;
        sw    = 16'h7F01;
        tick();
        start = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) seen = 1'b1;
            tick();
        end
        chk("notmo_busy", {31'd0, busy}, 32'd1);
        chk("notmo_nodone", {31'd0, seen}, 32'd0);
        chk("notmo_err", {31'd0, timeout_err}, 32'd0);
`endif

        start = 1'b1;
        op    = 3'd3;
        sw    = 16'h8001;
        tick();
        start = 1'b0;
        chk("rw_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_zero("rw", {busy, done, pass, timeout_err, halted},
                 expected, test_cnt, error_cnt);
        res       = 16'hFF7F;
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        chk("rw_nodone1", {30'd0, busy, done}, 32'd0);
        tick();
        chk("rw_nodone2", {30'd0, busy, done}, 32'd0);

        h_start = 1'b1;
        op      = 3'd2;
        sw      = 16'h7F01;
        tick();
        h_start   = 1'b0;
        res       = 16'h0000;
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        chk("h_done", {31'd0, h_done}, 32'd1);
        chk("h_pass", {31'd0, h_pass}, 32'd0);
        chk("h_error_cnt", {16'd0, h_error_cnt}, 32'd1);
        tick();
        chk("h_halted", {30'd0, h_halted, h_busy}, 32'd3);
        h_start   = 1'b1;
        res       = 16'h0080;
        res_valid = 1'b1;
        tick();
        tick();
        h_start   = 1'b0;
        res_valid = 1'b0;
        tick();
        chk("h_stay", {30'd0, h_halted, h_done}, 32'd2);
        chk("h_test_cnt", {16'd0, h_test_cnt}, 32'd1);
        h_reset = 1'b1;
        tick();
        h_reset = 1'b0;
        chk_zero("h_clr", {h_busy, h_done, h_pass, h_timeout_err, h_halted},
                 h_expected, h_test_cnt, h_error_cnt);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
